nco_phase_gen: RTL

- Phase-accumulator NCO front end that generates the 11-bit phase addresses consumed by the quarter-wave sine lookup stage.
- Supports continuous or fixed-length bursts, phase-continuous frequency retuning and a programmable start phase.
- Emits a valid delayed by the downstream lookup latency, so consumers know when each sine sample is present.

---
 rtl/nco_phase_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO front end producing quarter-wave LUT phase addresses with burst control.
// Optional build macro NCO_PHASE_DITHER_EN adds LFSR dither to the address truncation.
module nco_phase_gen #(
    parameter int unsigned PHASE_W     = 32,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned LUT_LATENCY = 3,
    parameter int unsigned BURST_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               freq_stb,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    input  logic               stop,
    output logic [ADDR_W-1:0]  addr,
    output logic               addr_valid,
    output logic               lut_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned FRAC_W = PHASE_W - ADDR_W;
    localparam int unsigned DCNT_W = $clog2(LUT_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   acc, acc_nxt;
    logic [PHASE_W-1:0]   freq_reg;
    logic [BURST_W-1:0]   cnt, cnt_nxt;
    logic                 cont, cont_nxt;
    logic [DCNT_W-1:0]    dcnt, dcnt_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic                 addr_valid_nxt;
    logic                 done_nxt;
    logic [LUT_LATENCY-1:0] vdly;
    logic [PHASE_W-1:0]   dither;

`ifdef NCO_PHASE_DITHER_EN
    localparam logic [PHASE_W-1:0] FRAC_MASK = (PHASE_W'(1) << FRAC_W) - PHASE_W'(1);
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11; advances only while generating
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (state == S_RUN) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dither = PHASE_W'(lfsr) & FRAC_MASK;
`else
    assign dither = '0;
`endif

    // Next-state and next-output logic; acc always holds the phase of the sample on addr
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        cont_nxt       = cont;
        dcnt_nxt       = dcnt;
        addr_valid_nxt = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    acc_nxt        = phase_offset;
                    cnt_nxt        = burst_len - BURST_W'(1);
                    cont_nxt       = (burst_len == '0);
                    addr_valid_nxt = 1'b1;
                    state_nxt      = S_RUN;
                end
            end
            S_RUN: begin
                if (stop || (!cont && cnt == '0)) begin
                    dcnt_nxt  = '0;
                    state_nxt = S_DRAIN;
                end else begin
                    acc_nxt        = acc + freq_reg;
                    addr_valid_nxt = 1'b1;
                    if (!cont) begin
                        cnt_nxt = cnt - BURST_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                done_nxt = (dcnt == DCNT_W'(LUT_LATENCY - 1));
                if (dcnt == DCNT_W'(LUT_LATENCY)) begin
                    state_nxt = S_IDLE;
                end else begin
                    dcnt_nxt = dcnt + DCNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        addr_nxt = addr_valid_nxt ? ADDR_W'((acc_nxt + dither) >> FRAC_W) : addr;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            freq_reg   <= '0;
            cnt        <= '0;
            cont       <= 1'b0;
            dcnt       <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            vdly       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            cont       <= cont_nxt;
            dcnt       <= dcnt_nxt;
            addr       <= addr_nxt;
            addr_valid <= addr_valid_nxt;
            vdly       <= LUT_LATENCY'({vdly, addr_valid});
            busy       <= (state_nxt != S_IDLE);
            done       <= done_nxt;
            if (freq_stb) begin
                freq_reg <= freq_word;
            end
        end
    end

    assign lut_valid = vdly[LUT_LATENCY-1];

endmodule
